nand_serial_adder: RTL and testbench

Bit-serial, parametrised-width add/subtract unit whose single-bit datapath is a full adder built only from 2-input NAND gates. It processes one bit per clock, LSB first, with a carry flip-flop between bits. It replaces wide combinational NAND ripple chains wherever area matters more than latency. A start/busy/done handshake lets a controller issue back-to-back operations.

---
 rtl/nand_adder_pkg.sv | 14 +
 rtl/nand_full_adder.sv | 26 ++
 rtl/nand_serial_adder.sv | 111 +++++++++++
 tb/tb_nand_serial_adder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/nand_adder_pkg.sv
// Shared types and helpers for the bit-serial NAND adder.
package nand_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/nand_full_adder.sv
// One-bit full adder built from nine 2-input NAND gates (two XOR groups in series).
module nand_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic n1, n2, n3, x1;
  logic m1, m2, m3;

  assign n1 = ~(a & b);
  assign n2 = ~(a & n1);
  assign n3 = ~(b & n1);
  assign x1 = ~(n2 & n3);

  assign m1 = ~(x1 & ci);
  assign m2 = ~(x1 & m1);
  assign m3 = ~(ci & m1);
  assign s  = ~(m2 & m3);

  // n1 is ~(a&b), m1 is ~((a^b)&ci); their NAND is the majority carry.
  assign co = ~(n1 & m1);

endmodule

// File: rtl/nand_serial_adder.sv
// Bit-serial add/subtract unit: one NAND full adder, LSB first, start/busy/done handshake.
module nand_serial_adder
  import nand_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  adder_state_t     state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic             cmsb_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_co;

  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;

  nand_full_adder u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cmsb_reg  <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b_load;
            carry_reg <= c_load;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ADD;
          end else begin
            state_reg <= IDLE;
          end
        end
        ADD: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
          carry_reg <= fa_co;
          if (cnt_reg == PENULT) cmsb_reg <= fa_co;
          if (cnt_reg == LAST) begin
            sum_reg   <= {fa_s, res_reg[WIDTH-1:1]};
            cout_reg  <= fa_co;
            ovf_reg   <= cmsb_reg ^ fa_co;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_nand_serial_adder.sv
// Directed plus randomized bench for nand_serial_adder against an arithmetic reference.
module tb_nand_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  nand_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the sampled operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mcin, input logic msub);
    int unsigned r;
    int sa, sb, sr;
    sa = $signed(ma);
    sb = $signed(mb);
    if (msub) begin
      r  = (int'(ma) - int'(mb)) & ((1 << W) - 1);
      exp_cout = (ma >= mb);
      sr = sa - sb;
    end else begin
      r  = int'(ma) + int'(mb) + int'(mcin);
      exp_cout = (r >= (1 << W));
      sr = sa + sb + int'(mcin);
    end
    exp_sum = W'(r);
    exp_ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endtask

  // Called about 1 time unit after a rising edge; start is sampled at the next edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    model(ia, ib, icin, isub);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic track(input string tag, input bit poke);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      chk({tag, ".done"}, 32'(done), 32'(i == W));
      chk({tag, ".busy"}, 32'(busy), 32'(i < W));
      if (poke && (i == 2 || i == 5)) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, ".sum"},  32'(sum),  32'(exp_sum));
    chk({tag, ".cout"}, 32'(cout), 32'(exp_cout));
    chk({tag, ".ovf"},  32'(ovf),  32'(exp_ovf));
    $display("op %s sum=%02h cout=%0b ovf=%0b exp=%02h/%0b/%0b",
             tag, sum, cout, ovf, exp_sum, exp_cout, exp_ovf);
  endtask

  initial begin
    // Reset held with inputs toggling.
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); a = W'($urandom); b = W'($urandom);
      sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      chk("rst.outs", {21'd0, sum, cout, ovf, busy, done}, 32'd0);
    end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.busy", 32'(busy), 32'd0);

    issue(8'h3C, 8'h45, 1'b0, 1'b0);
    chk("dir1.model", {23'd0, exp_sum, exp_ovf}, {23'd0, 8'h81, 1'b1});
    track("add_3c_45", 1'b0);

    issue(8'hFF, 8'h00, 1'b1, 1'b0);
    track("add_ff_00", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.sum",  32'(sum),  32'h00);
    chk("hold.cout", 32'(cout), 32'd1);
    chk("hold.done", 32'(done), 32'd0);

    issue(8'h10, 8'h20, 1'b1, 1'b1);
    track("sub_10_20", 1'b0);
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    track("sub_80_01_b2b", 1'b0);

    issue(8'h5A, 8'h33, 1'b0, 1'b0);
    track("ignore_start", 1'b1);
    @(posedge clk); #1;
    chk("ignore.done2", 32'(done), 32'd0);
    chk("ignore.busy2", 32'(busy), 32'd0);
    chk("ignore.sum2",  32'(sum),  32'(exp_sum));

    // Reset mid-operation.
    issue(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.outs", {21'd0, sum, cout, ovf, busy, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.idle", {21'd0, sum, cout, ovf, busy, done}, 32'd0);
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    track("after_rst_01_01", 1'b0);

    // Randomized operations, some back-to-back.
    for (int n = 0; n < 24; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      track($sformatf("rand%0d", n), 1'b0);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
